hazard_sb: RTL and testbench

Scoreboarded hazard unit for the five-stage pipelined core. It is the successor to the combinational forward/stall/flush logic, and sits beside the pipeline registers, driving their stall/flush controls and the E-stage operand muxes. It is parametrised in register-file size and adds three things:
- a per-register pending scoreboard for a non-pipelined multi-cycle unit (MDU);
- whole-pipe freeze on a data-memory wait;
- a saturating stall-cycle counter.

---
 rtl/hazard_sb_pkg.sv | 14 +
 rtl/hazard_scoreboard.sv | 56 +++++
 rtl/hazard_sb.sv | 117 +++++++++++
 tb/tb_hazard_sb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_sb_pkg.sv
// Shared encodings for the hazard unit: writeback-select codes and operand
// forwarding selects for the E-stage muxes.
package hazard_sb_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_LSU = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
  localparam logic [1:0] WB_SEL_MDU = 2'd3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_M  = 2'd1;
  localparam logic [1:0] FWD_W  = 2'd2;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for the multi-cycle unit, the busy flag, and a
// three-port pending lookup that treats a same-cycle writeback as released.
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_i,
  input  logic [AW-1:0] issue_addr_i,
  input  logic          clr_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] qa_addr_i,
  input  logic [AW-1:0] qb_addr_i,
  input  logic [AW-1:0] qc_addr_i,
  output logic          qa_pend_o,
  output logic          qb_pend_o,
  output logic          qc_pend_o,
  output logic          busy_o
);

  logic [NREG-1:0] sb_q, sb_d;
  logic            busy_q, busy_d;

  // Set is applied after clear so a same-cycle set to the same index wins.
  always_comb begin
    sb_d   = sb_q;
    busy_d = busy_q;
    if (clr_i) begin
      sb_d[clr_addr_i] = 1'b0;
      busy_d           = 1'b0;
    end
    if (issue_i) begin
      sb_d[issue_addr_i] = 1'b1;
      busy_d             = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      busy_q <= busy_d;
    end
  end

  // Register file is write-through, so the writeback cycle itself is clean.
  assign qa_pend_o = sb_q[qa_addr_i] & ~(clr_i & (clr_addr_i == qa_addr_i));
  assign qb_pend_o = sb_q[qb_addr_i] & ~(clr_i & (clr_addr_i == qb_addr_i));
  assign qc_pend_o = sb_q[qc_addr_i] & ~(clr_i & (clr_addr_i == qc_addr_i));
  assign busy_o    = busy_q;

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit for the five-stage core: operand forwarding, load-use and MDU
// scoreboard stalls, memory-wait freeze, branch flush and a stall counter.
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int AW    = $clog2(NREG),
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addrD,
  input  logic [AW-1:0]    rs2_addrD,
  input  logic             rs1_useD,
  input  logic             rs2_useD,
  input  logic [AW-1:0]    rd_addrD,
  input  logic             rd_wr_enD,
  input  logic             mc_opD,
  input  logic [AW-1:0]    rs1_addrE,
  input  logic [AW-1:0]    rs2_addrE,
  input  logic [AW-1:0]    rd_addrE,
  input  logic             rd_wr_enE,
  input  logic             mc_opE,
  input  logic [1:0]       wb_selE,
  input  logic             br_selE,
  input  logic [AW-1:0]    rd_addrM,
  input  logic [AW-1:0]    rd_addrW,
  input  logic             rd_wr_enM,
  input  logic             rd_wr_enW,
  input  logic             mc_wb_en,
  input  logic [AW-1:0]    mc_wb_addr,
  input  logic             lsu_waitM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic [1:0]       fwa_sel,
  output logic [1:0]       fwb_sel,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             issue;
  logic             pend_rs1, pend_rs2, pend_rd;
  logic             lw_haz, sb_haz, mdu_haz, dhaz;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // E only stalls on a memory wait, so that is the sole issue blocker.
  assign issue = mc_opE & rd_wr_enE & ~lsu_waitM & (rd_addrE != '0);

  hazard_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_i      (issue),
    .issue_addr_i (rd_addrE),
    .clr_i        (mc_wb_en),
    .clr_addr_i   (mc_wb_addr),
    .qa_addr_i    (rs1_addrD),
    .qb_addr_i    (rs2_addrD),
    .qc_addr_i    (rd_addrD),
    .qa_pend_o    (pend_rs1),
    .qb_pend_o    (pend_rs2),
    .qc_pend_o    (pend_rd),
    .busy_o       (mdu_busy)
  );

  assign fwa_sel = (rs1_addrE == '0)                      ? FWD_RF :
                   (rd_wr_enM && rs1_addrE == rd_addrM)   ? FWD_M  :
                   (rd_wr_enW && rs1_addrE == rd_addrW)   ? FWD_W  : FWD_RF;
  assign fwb_sel = (rs2_addrE == '0)                      ? FWD_RF :
                   (rd_wr_enM && rs2_addrE == rd_addrM)   ? FWD_M  :
                   (rd_wr_enW && rs2_addrE == rd_addrW)   ? FWD_W  : FWD_RF;

  assign lw_haz  = (wb_selE == WB_SEL_LSU) & rd_wr_enE & (rd_addrE != '0) &
                   ((rs1_useD & (rs1_addrD == rd_addrE)) |
                    (rs2_useD & (rs2_addrD == rd_addrE)));
  assign sb_haz  = (pend_rs1 & rs1_useD) | (pend_rs2 & rs2_useD) | (pend_rd & rd_wr_enD);
  assign mdu_haz = mc_opD & (mdu_busy | issue) & ~mc_wb_en;
  assign dhaz    = lw_haz | sb_haz | mdu_haz;

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (lsu_waitM) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (br_selE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (dhaz) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: a table of single-cycle vectors from the idle state,
// then hand-built multi-cycle sequences for the scoreboard, waits and counter.
module tb_hazard_sb;
  import hazard_sb_pkg::*;

  localparam int CW = 4;

  typedef struct packed {
    logic [4:0]    rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW, mcwa;
    logic          u1, u2, wrD, mcD, wrE, mcE;
    logic [1:0]    wbE;
    logic          br, wrM, wrW, mcw, lsuw;
    logic [10:0]   exp;
    logic          chk_cnt;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  // Expected word: {stallF,stallD,stallE,stallM,flushD,flushE,fwa,fwb,mdu_busy}
  localparam logic [10:0] E_IDLE = 11'b000000_00_00_0;
  localparam logic [10:0] E_LU   = 11'b110001_00_00_0;
  localparam logic [10:0] E_BR   = 11'b000011_00_00_0;
  localparam logic [10:0] E_WAIT = 11'b111100_00_00_0;
  localparam logic [10:0] E_BZ   = 11'b000000_00_00_1;

  logic clk, rst;
  logic [4:0] rs1_addrD, rs2_addrD, rd_addrD, rs1_addrE, rs2_addrE, rd_addrE;
  logic [4:0] rd_addrM, rd_addrW, mc_wb_addr;
  logic rs1_useD, rs2_useD, rd_wr_enD, mc_opD, rd_wr_enE, mc_opE, br_selE;
  logic rd_wr_enM, rd_wr_enW, mc_wb_en, lsu_waitM;
  logic [1:0] wb_selE;
  logic stallF, stallD, stallE, stallM, flushD, flushE, mdu_busy;
  logic [1:0] fwa_sel, fwb_sel;
  logic [CW-1:0] stall_cnt;

  logic [10:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  vec_t v;

  hazard_sb #(.NREG(32), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
    .rs1_useD(rs1_useD), .rs2_useD(rs2_useD),
    .rd_addrD(rd_addrD), .rd_wr_enD(rd_wr_enD), .mc_opD(mc_opD),
    .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rd_addrE(rd_addrE),
    .rd_wr_enE(rd_wr_enE), .mc_opE(mc_opE), .wb_selE(wb_selE), .br_selE(br_selE),
    .rd_addrM(rd_addrM), .rd_addrW(rd_addrW),
    .rd_wr_enM(rd_wr_enM), .rd_wr_enW(rd_wr_enW),
    .mc_wb_en(mc_wb_en), .mc_wb_addr(mc_wb_addr), .lsu_waitM(lsu_waitM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .fwa_sel(fwa_sel), .fwb_sel(fwb_sel),
    .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [10:0] fw(input logic [1:0] fa, input logic [1:0] fb);
    return {6'b0, fa, fb, 1'b0};
  endfunction

  // Driver
  task automatic apply(input vec_t x);
    rs1_addrD = x.rs1D; rs2_addrD = x.rs2D; rd_addrD = x.rdD;
    rs1_useD = x.u1; rs2_useD = x.u2; rd_wr_enD = x.wrD; mc_opD = x.mcD;
    rs1_addrE = x.rs1E; rs2_addrE = x.rs2E; rd_addrE = x.rdE;
    rd_wr_enE = x.wrE; mc_opE = x.mcE; wb_selE = x.wbE; br_selE = x.br;
    rd_addrM = x.rdM; rd_wr_enM = x.wrM; rd_addrW = x.rdW; rd_wr_enW = x.wrW;
    mc_wb_en = x.mcw; mc_wb_addr = x.mcwa; lsu_waitM = x.lsuw;
    exp_q.push_back(x.exp);
  endtask

  // Scoreboard check: pop the oldest expectation and compare
  task automatic check_out(input string name, input logic chk_cnt, input logic [CW-1:0] exp_cnt);
    logic [10:0] act, e;
    act = {stallF, stallD, stallE, stallM, flushD, flushE, fwa_sel, fwb_sel, mdu_busy};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued, got %b", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b want %b (sF sD sE sM fD fE fwa fwb busy)", name, act, e);
      end
    end
    if (chk_cnt) begin
      checks++;
      if (stall_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, exp_cnt);
      end
    end
  endtask

  task automatic step(input vec_t x, input string name);
    apply(x);
    @(negedge clk);
    check_out(name, x.chk_cnt, x.exp_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    v = '0;
    apply(v);
    void'(exp_q.pop_front());
    do_reset();

    // Reset state with idle inputs
    v = '0; v.exp = E_IDLE; v.chk_cnt = 1'b1; v.exp_cnt = '0;
    step(v, "reset_idle");

    // Single-cycle vectors from idle state (no MDU issue)
    v = '0; v.exp = E_IDLE; tbl.push_back(v);
    v = '0; v.rdE = 5; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs2D = 5; v.u2 = 1; v.exp = E_LU; tbl.push_back(v);
    v = '0; v.rdE = 5; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs2D = 5; v.u2 = 0; v.exp = E_IDLE; tbl.push_back(v);
    v = '0; v.rdE = 0; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 0; v.u1 = 1; v.exp = E_IDLE; tbl.push_back(v);
    v = '0; v.rdE = 5; v.wrE = 1; v.wbE = WB_SEL_ALU; v.rs1D = 5; v.u1 = 1; v.exp = E_IDLE; tbl.push_back(v);
    v = '0; v.rdE = 6; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 6; v.u1 = 1; v.exp = E_LU; tbl.push_back(v);
    v = '0; v.rdE = 6; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 6; v.u1 = 1; v.br = 1; v.exp = E_BR; tbl.push_back(v);
    v = '0; v.rdE = 6; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 6; v.u1 = 1; v.br = 1; v.lsuw = 1; v.exp = E_WAIT; tbl.push_back(v);
    v = '0; v.rs1E = 3; v.rdM = 3; v.wrM = 1; v.rdW = 3; v.wrW = 1; v.exp = fw(FWD_M, FWD_RF); tbl.push_back(v);
    v = '0; v.rs1E = 3; v.rdM = 3; v.wrM = 0; v.rdW = 3; v.wrW = 1; v.exp = fw(FWD_W, FWD_RF); tbl.push_back(v);
    v = '0; v.rs1E = 0; v.rdM = 0; v.wrM = 1; v.rdW = 0; v.wrW = 1; v.exp = fw(FWD_RF, FWD_RF); tbl.push_back(v);
    v = '0; v.rs1E = 9; v.rs2E = 4; v.rdM = 4; v.rdW = 4; v.wrW = 1; v.exp = fw(FWD_RF, FWD_W); tbl.push_back(v);
    v = '0; v.rs1E = 6; v.rs2E = 6; v.rdM = 6; v.wrM = 1; v.exp = fw(FWD_M, FWD_M); tbl.push_back(v);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Load-use: one bubble, then operand forwarded from W
    do_reset();
    v = '0; v.rdE = 5; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs2D = 5; v.u2 = 1; v.exp = E_LU; step(v, "lu_stall");
    v = '0; v.rdM = 5; v.wrM = 1; v.rs2D = 5; v.u2 = 1; v.exp = E_IDLE; v.chk_cnt = 1; v.exp_cnt = 1; step(v, "lu_bubble");
    v = '0; v.rs2E = 5; v.rdW = 5; v.wrW = 1; v.exp = fw(FWD_RF, FWD_W); step(v, "lu_fwd_w");

    // MDU result to x7, consumer held until the writeback cycle
    do_reset();
    v = '0; v.mcE = 1; v.wrE = 1; v.rdE = 7; v.rs1D = 7; v.u1 = 1; v.exp = E_IDLE; step(v, "mdu_issue");
    for (int i = 0; i < 3; i++) begin
      v = '0; v.rs1D = 7; v.u1 = 1; v.exp = E_LU | E_BZ; v.chk_cnt = 1; v.exp_cnt = CW'(i);
      step(v, $sformatf("mdu_wait%0d", i));
    end
    v = '0; v.rs1D = 7; v.u1 = 1; v.mcw = 1; v.mcwa = 7; v.exp = E_BZ; v.chk_cnt = 1; v.exp_cnt = 3; step(v, "mdu_release");
    v = '0; v.rs1D = 7; v.u1 = 1; v.exp = E_IDLE; v.chk_cnt = 1; v.exp_cnt = 3; step(v, "mdu_done");

    // Back-to-back MDU ops, then WAW on x7 from a plain instruction
    v = '0; v.mcE = 1; v.wrE = 1; v.rdE = 7; v.mcD = 1; v.rdD = 8; v.wrD = 1; v.exp = E_LU; step(v, "b2b_issue");
    v = '0; v.mcD = 1; v.rdD = 8; v.wrD = 1; v.exp = E_LU | E_BZ; step(v, "b2b_busy");
    v = '0; v.rdD = 7; v.wrD = 1; v.exp = E_LU | E_BZ; step(v, "waw_x7");
    v = '0; v.rdD = 7; v.wrD = 1; v.mcw = 1; v.mcwa = 7; v.exp = E_BZ; step(v, "waw_release");
    v = '0; v.exp = E_IDLE; step(v, "b2b_idle");

    // Same-cycle set and clear on x10: set wins
    v = '0; v.mcE = 1; v.wrE = 1; v.rdE = 10; v.mcw = 1; v.mcwa = 10; v.exp = E_IDLE; step(v, "setclr");
    v = '0; v.rs2D = 10; v.u2 = 1; v.exp = E_LU | E_BZ; step(v, "setclr_pend");
    v = '0; v.rs2D = 10; v.u2 = 1; v.mcw = 1; v.mcwa = 10; v.exp = E_BZ; step(v, "setclr_rel");
    v = '0; v.exp = E_IDLE; step(v, "setclr_idle");

    // Issue blocked while memory holds the pipe
    v = '0; v.mcE = 1; v.wrE = 1; v.rdE = 11; v.lsuw = 1; v.exp = E_WAIT; step(v, "wait_noissue");
    v = '0; v.rs1D = 11; v.u1 = 1; v.exp = E_IDLE; step(v, "wait_noissue_chk");

    // Memory wait over a taken branch, then the flush lands
    for (int i = 0; i < 3; i++) begin
      v = '0; v.br = 1; v.lsuw = 1; v.rdE = 6; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 6; v.u1 = 1;
      v.exp = E_WAIT; step(v, $sformatf("wait_br%0d", i));
    end
    v = '0; v.br = 1; v.exp = E_BR; step(v, "br_after_wait");

    // Reset in the middle of an outstanding MDU op
    v = '0; v.mcE = 1; v.wrE = 1; v.rdE = 9; v.exp = E_IDLE; step(v, "rst_issue");
    v = '0; v.rs1D = 9; v.u1 = 1; v.exp = E_LU | E_BZ; step(v, "rst_pend");
    do_reset();
    v = '0; v.rs1D = 9; v.u1 = 1; v.exp = E_IDLE; v.chk_cnt = 1; v.exp_cnt = 0; step(v, "rst_cleared");

    // Counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v = '0; v.rdE = 5; v.wrE = 1; v.wbE = WB_SEL_LSU; v.rs1D = 5; v.u1 = 1; v.exp = E_LU;
      v.chk_cnt = 1; v.exp_cnt = (i < 15) ? CW'(i) : CW'(15);
      step(v, $sformatf("sat%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
